uart_cfg_core: RTL and testbench
================================

UART_CFG_CORE -- requirements
Module: uart_cfg_core

Interface
REQ-001 Parameter CLK_FREQ, default 1000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: line bit rate; BIT_DIV = CLK_FREQ/BAUD (integer truncation) SHALL be the clocks per bit; 1000000/9600 gives 104.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9: payload bits per frame.
REQ-004 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal 1..2: stop bits sent; receiver checks only the first.
REQ-006 Parameter RX_DEPTH, default 4, power of two >= 2: RX FIFO entries.
REQ-007 clk  in  1  system clock; all logic on the rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 rx  in  1  serial input, idle high, asynchronous to clk.
REQ-010 dintx  in  DATA_BITS  TX payload, sampled when newd is accepted.
REQ-011 newd  in  1  TX request; accepted only while txbusy = 0.
REQ-012 tx  out  1  serial output, idle high.
REQ-013 txbusy  out  1  high from the cycle after acceptance to the end of the last stop bit.
REQ-014 donetx  out  1  one-cycle pulse at the end of the last stop bit.
REQ-015 doutrx  out  DATA_BITS  FIFO head data, valid while rx_valid = 1.
REQ-016 rx_valid  out  1  FIFO not empty.
REQ-017 rx_rd  in  1  pop FIFO head; ignored when rx_valid = 0.
REQ-018 donerx  out  1  one-cycle pulse when a frame completes, whether good or errored.
REQ-019 parity_err, frame_err  out  1 each  sticky; set on a bad frame; cleared by clr_err.
REQ-020 overflow  out  1  sticky; set when a frame completes while the FIFO is full; cleared by clr_err.
REQ-021 clr_err  in  1  synchronous clear of the three sticky flags.

Function
REQ-022 Frame format SHALL be: start bit 0, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits of 1; each bit lasts exactly BIT_DIV clocks.
REQ-023 The TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY = 0.
REQ-024 In IDLE, newd = 1 SHALL latch dintx and enter START on the next edge; tx goes low in the same cycle.
REQ-025 newd asserted while txbusy = 1 SHALL be ignored; no queuing.
REQ-026 Back-to-back: newd held high across donetx SHALL start the next frame on the cycle after donetx, so there is no extra idle bit.
REQ-027 The rx input SHALL pass through a 2-flop synchroniser before use.
REQ-028 The RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-029 IDLE -> START on a synchronised falling edge of rx.
REQ-030 START SHALL re-sample at BIT_DIV/2 clocks (52 at the defaults); if rx is high there, the start is false and the FSM returns to IDLE with no donerx.
REQ-031 After a valid start, every later bit SHALL be sampled BIT_DIV clocks after the previous sample, i.e. at mid-bit.
REQ-032 Parity error: received parity != XOR of the data bits (even mode) or its complement (odd mode).
REQ-033 Frame error: first stop-bit sample = 0.
REQ-034 Frame completion occurs at the stop sample; donerx SHALL pulse in that cycle and the FSM returns to IDLE.
REQ-035 A good frame SHALL be pushed to the FIFO.
REQ-036 A frame with a parity or frame error SHALL NOT be pushed; it sets the matching sticky flag.
REQ-037 FIFO full with a good frame completing: the frame is dropped, existing contents are kept, and overflow is set.
REQ-038 Simultaneous pop and push with the FIFO full SHALL pop the head and push the new word, with no overflow.
REQ-039 The FIFO pointers SHALL be log2(RX_DEPTH)+1 bits and wrap naturally.
REQ-040 doutrx SHALL be the combinational read of the head entry.
REQ-041 clr_err and a new error in the same cycle: the error wins and the flag stays set.
REQ-042 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-043 rst = 0 SHALL asynchronously force: tx = 1; txbusy, donetx, donerx, rx_valid, parity_err, frame_err, overflow = 0; doutrx = 0; both FSMs to IDLE; bit counters and FIFO pointers to 0; synchroniser flops to 1.
REQ-044 Reset asserted mid-frame SHALL abort the frame without any done pulse; after release the block SHALL wait for a fresh start edge.

Structure
REQ-045 A shared package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the TX/RX state enum typedefs.
REQ-046 The RX FIFO SHALL be a separate sub-module, uart_rx_fifo, parametrised by width and depth; TX and RX logic stay in uart_cfg_core.

Verification
REQ-047 Defaults: send 0xA5 with tx looped to rx -> tx low for 104 clocks, bits 1,0,1,0,0,1,0,1 at 104 clocks each; donetx at 1040 clocks; rx_valid rises and doutrx = 0xA5.
REQ-048 PARITY = 1, DATA_BITS = 7: drive a frame for 0x55 with parity bit 1 -> parity_err = 1, donerx pulses, rx_valid stays 0.
REQ-049 A stop bit driven to 0 -> frame_err = 1; a clr_err pulse -> frame_err = 0.
REQ-050 A 30-clock low glitch on rx -> no donerx, FSM back in IDLE.
REQ-051 Five good frames received with no reads at RX_DEPTH = 4 -> FIFO holds the first four bytes, overflow = 1; four rx_rd pops return bytes 1-4 in order.
REQ-052 Assert rst mid-DATA during TX and RX -> tx = 1 immediately, no done pulses; the next frame after release is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state types for the configurable UART core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPop, doPush;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign doPop   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + (AW+1)'(1);
      if (doPop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_cfg_core.sv
// Configurable UART: independent TX and RX state machines plus an RX FIFO with sticky error flags.
module uart_cfg_core import uart_pkg::*; #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] dintx,
  input  logic                 newd,
  output logic                 tx,
  output logic                 txbusy,
  output logic                 donetx,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 rx_valid,
  input  logic                 rx_rd,
  output logic                 donerx,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 clr_err
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_MODE  = (PARITY == PAR_ODD);

  tx_state_e            txState_q, txState_d;
  logic [CW-1:0]        txCnt_q, txCnt_d;
  logic [3:0]           txBit_q, txBit_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic                 txPar_q, txPar_d, txStop_q, txStop_d, txDone_q, txDone_d;
  logic                 txTick;

  assign txTick = (txCnt_q == DIV_LAST);
  assign txbusy = (txState_q != TX_IDLE);
  assign donetx = txDone_q;

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txTick ? '0 : txCnt_q + CW'(1);
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    txStop_d  = txStop_q;
    txDone_d  = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        txCnt_d = '0;
        if (newd) begin
          txShift_d = dintx;
          txPar_d   = (^dintx) ^ ODD_MODE;
          txBit_d   = '0;
          txStop_d  = 1'b0;
          txState_d = TX_START;
        end
      end
      TX_START: if (txTick) txState_d = TX_DATA;
      TX_DATA: if (txTick) begin
        txShift_d = txShift_q >> 1;
        txBit_d   = txBit_q + 4'd1;
        if (txBit_q == DB_LAST) txState_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: if (txTick) txState_d = TX_STOP;
      TX_STOP: if (txTick) begin
        if (txStop_q == STOP_LAST) begin
          txState_d = TX_IDLE;
          txDone_d  = 1'b1;
        end else begin
          txStop_d = 1'b1;
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (txState_q)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = txShift_q[0];
      TX_PARITY: tx = txPar_q;
      default:   tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      txStop_q  <= 1'b0;
      txDone_q  <= 1'b0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txPar_q   <= txPar_d;
      txStop_q  <= txStop_d;
      txDone_q  <= txDone_d;
    end
  end

  rx_state_e            rxState_q, rxState_d;
  logic [CW-1:0]        rxCnt_q, rxCnt_d;
  logic [3:0]           rxBit_q, rxBit_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
  logic                 rxPar_q, rxPar_d;
  logic                 rxMeta_q, rxSync_q, rxPrev_q;
  logic                 rxTick, parErrNow, frmErrNow, pushReq, fifoFull, fifoEmpty, ovfNow;
  logic                 parErr_q, frmErr_q, ovf_q;

  assign rxTick = (rxCnt_q == DIV_LAST);

  // Start is confirmed at half a bit; from then every sample lands at mid-bit.
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q + CW'(1);
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxPar_d   = rxPar_q;
    donerx    = 1'b0;
    parErrNow = 1'b0;
    frmErrNow = 1'b0;
    pushReq   = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        rxCnt_d = '0;
        if (rxPrev_q && !rxSync_q) rxState_d = RX_START;
      end
      RX_START: if (rxCnt_q == HALF_LAST) begin
        rxCnt_d   = '0;
        rxBit_d   = '0;
        rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rxTick) begin
        rxCnt_d   = '0;
        rxShift_d = {rxSync_q, rxShift_q[DATA_BITS-1:1]};
        rxBit_d   = rxBit_q + 4'd1;
        if (rxBit_q == DB_LAST) rxState_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: if (rxTick) begin
        rxCnt_d   = '0;
        rxPar_d   = rxSync_q;
        rxState_d = RX_STOP;
      end
      RX_STOP: if (rxTick) begin
        rxCnt_d   = '0;
        donerx    = 1'b1;
        frmErrNow = !rxSync_q;
        parErrNow = (PARITY != PAR_NONE) && (rxPar_q != ((^rxShift_q) ^ ODD_MODE));
        pushReq   = !frmErrNow && !parErrNow;
        rxState_d = RX_IDLE;
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  assign ovfNow = pushReq && fifoFull && !rx_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxPar_q   <= 1'b0;
      parErr_q  <= 1'b0;
      frmErr_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rxMeta_q  <= rx;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
      rxPar_q   <= rxPar_d;
      parErr_q  <= (parErr_q && !clr_err) || parErrNow;
      frmErr_q  <= (frmErr_q && !clr_err) || frmErrNow;
      ovf_q     <= (ovf_q && !clr_err) || ovfNow;
    end
  end

  assign parity_err = parErr_q;
  assign frame_err  = frmErr_q;
  assign overflow   = ovf_q;
  assign rx_valid   = !fifoEmpty;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushReq),
    .wdata_i (rxShift_q),
    .pop_i   (rx_rd),
    .rdata_o (doutrx),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed bench: default 8N1 core in loopback/driven mode plus a 7-bit even-parity instance.
module tb_uart_cfg_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       loop, rxDrv, newd, rx_rd, clr_err;
  logic [7:0] dintx;
  logic       tx, txbusy, donetx, rx_valid, donerx, parity_err, frame_err, overflow;
  logic [7:0] doutrx;
  logic       rxMain;
  assign rxMain = loop ? tx : rxDrv;

  logic       rxP;
  logic       txP, txbusyP, donetxP, rx_validP, donerxP, parity_errP, frame_errP, overflowP;
  logic [6:0] doutrxP;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int doneTxCnt = 0;
  int doneRxCnt = 0;
  int doneRxPCnt = 0;

  uart_cfg_core dut (
    .clk(clk), .rst(rst), .rx(rxMain), .dintx(dintx), .newd(newd), .tx(tx),
    .txbusy(txbusy), .donetx(donetx), .doutrx(doutrx), .rx_valid(rx_valid),
    .rx_rd(rx_rd), .donerx(donerx), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .clr_err(clr_err)
  );

  uart_cfg_core #(.DATA_BITS(7), .PARITY(1)) dutP (
    .clk(clk), .rst(rst), .rx(rxP), .dintx(7'h00), .newd(1'b0), .tx(txP),
    .txbusy(txbusyP), .donetx(donetxP), .doutrx(doutrxP), .rx_valid(rx_validP),
    .rx_rd(1'b0), .donerx(donerxP), .parity_err(parity_errP), .frame_err(frame_errP),
    .overflow(overflowP), .clr_err(1'b0)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (donetx)  doneTxCnt  <= doneTxCnt + 1;
    if (donerx)  doneRxCnt  <= doneRxCnt + 1;
    if (donerxP) doneRxPCnt <= doneRxPCnt + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n line bits LSB first, 104 clocks each, onto the main or the parity instance.
  task automatic applyStimulus(input logic [15:0] bits, input int n, input bit toP);
    for (int i = 0; i < n; i++) begin
      if (toP) rxP = bits[i];
      else     rxDrv = bits[i];
      tick(104);
    end
    if (toP) rxP = 1'b1;
    else     rxDrv = 1'b1;
  endtask

  task automatic waitDoneTx(input string tag, input int budget);
    int k = 0;
    while (!donetx && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, 16'(donetx), 16'd1);
  endtask

  int         t0, base, baseRx;
  logic [7:0] expByte;
  logic [7:0] ovfBytes [5];

  initial begin
    loop = 1'b0; rxDrv = 1'b1; rxP = 1'b1; newd = 1'b0; dintx = 8'h00;
    rx_rd = 1'b0; clr_err = 1'b0;
    ovfBytes[0] = 8'h11; ovfBytes[1] = 8'h22; ovfBytes[2] = 8'h33;
    ovfBytes[3] = 8'h44; ovfBytes[4] = 8'h55;
    $display("[TB] start");
    tick(3);
    checkOutput("rst_tx", 16'(tx), 16'd1);
    checkOutput("rst_txbusy", 16'(txbusy), 16'd0);
    checkOutput("rst_donetx", 16'(donetx), 16'd0);
    checkOutput("rst_donerx", 16'(donerx), 16'd0);
    checkOutput("rst_rx_valid", 16'(rx_valid), 16'd0);
    checkOutput("rst_doutrx", 16'(doutrx), 16'd0);
    checkOutput("rst_flags", 16'({parity_err, frame_err, overflow}), 16'd0);
    rst = 1'b1;
    tick(2);

    // Loopback of 0xA5: bit timing, donetx latency and reception.
    loop = 1'b1; dintx = 8'hA5; newd = 1'b1;
    tick();
    newd = 1'b0; t0 = cyc;
    checkOutput("start_low", 16'(tx), 16'd0);
    checkOutput("start_busy", 16'(txbusy), 16'd1);
    tick(52);
    checkOutput("start_mid", 16'(tx), 16'd0);
    expByte = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick(104);
      checkOutput($sformatf("a5_bit%0d", i), 16'(tx), 16'(expByte[i]));
    end
    tick(104);
    checkOutput("a5_stop", 16'(tx), 16'd1);
    waitDoneTx("a5_donetx", 200);
    checkOutput("a5_done_time", 16'(cyc - t0), 16'd1040);
    checkOutput("a5_done_notbusy", 16'(txbusy), 16'd0);
    checkOutput("a5_rx_valid", 16'(rx_valid), 16'd1);
    checkOutput("a5_doutrx", 16'(doutrx), 16'h00A5);
    checkOutput("a5_donerx_cnt", 16'(doneRxCnt), 16'd1);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    checkOutput("a5_popped", 16'(rx_valid), 16'd0);

    // Back-to-back: newd held through donetx starts the next frame immediately.
    dintx = 8'h3C; newd = 1'b1;
    tick();
    dintx = 8'hC3;
    checkOutput("b2b_busy1", 16'(txbusy), 16'd1);
    waitDoneTx("b2b_done1", 1200);
    checkOutput("b2b_idle_at_done", 16'(txbusy), 16'd0);
    tick();
    checkOutput("b2b_start2", 16'(tx), 16'd0);
    checkOutput("b2b_busy2", 16'(txbusy), 16'd1);
    newd = 1'b0;
    waitDoneTx("b2b_done2", 1200);
    tick(5);
    checkOutput("no_queue", 16'(txbusy), 16'd0);
    checkOutput("b2b_head1", 16'(doutrx), 16'h003C);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    checkOutput("b2b_head2", 16'(doutrx), 16'h00C3);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    checkOutput("b2b_empty", 16'(rx_valid), 16'd0);

    // Frame error on a zero stop bit, then clear.
    loop = 1'b0;
    base = doneRxCnt;
    applyStimulus(16'h00B4, 10, 1'b0);
    tick(20);
    checkOutput("ferr_set", 16'(frame_err), 16'd1);
    checkOutput("ferr_nopush", 16'(rx_valid), 16'd0);
    checkOutput("ferr_donerx", 16'(doneRxCnt - base), 16'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checkOutput("ferr_cleared", 16'(frame_err), 16'd0);

    // 30-clock glitch is rejected as a false start.
    base = doneRxCnt;
    rxDrv = 1'b0; tick(30); rxDrv = 1'b1;
    tick(300);
    checkOutput("glitch_nodone", 16'(doneRxCnt - base), 16'd0);
    checkOutput("glitch_novalid", 16'(rx_valid), 16'd0);

    // Five frames into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      applyStimulus({6'b0, 1'b1, ovfBytes[i], 1'b0}, 10, 1'b0);
      tick(5);
      if (i == 3) checkOutput("ovf_not_yet", 16'(overflow), 16'd0);
    end
    checkOutput("ovf_set", 16'(overflow), 16'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_pop%0d", i), 16'(doutrx), 16'(ovfBytes[i]));
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    end
    checkOutput("ovf_drained", 16'(rx_valid), 16'd0);

    // Parity instance: 0x55 has even parity 0, so a parity bit of 1 is an error.
    applyStimulus(16'h03AA, 10, 1'b1);
    tick(5);
    checkOutput("perr_set", 16'(parity_errP), 16'd1);
    checkOutput("perr_donerx", 16'(doneRxPCnt), 16'd1);
    checkOutput("perr_nopush", 16'(rx_validP), 16'd0);
    applyStimulus(16'h02AA, 10, 1'b1);
    tick(5);
    checkOutput("pgood_valid", 16'(rx_validP), 16'd1);
    checkOutput("pgood_data", 16'(doutrxP), 16'h0055);
    checkOutput("pgood_sticky", 16'(parity_errP), 16'd1);
    checkOutput("pgood_noferr", 16'(frame_errP), 16'd0);

    // Reset mid-frame aborts both directions without done pulses.
    loop = 1'b1;
    base = doneTxCnt; baseRx = doneRxCnt;
    dintx = 8'h96; newd = 1'b1;
    tick();
    newd = 1'b0;
    tick(400);
    rst = 1'b0;
    #1;
    checkOutput("mrst_tx", 16'(tx), 16'd1);
    checkOutput("mrst_busy", 16'(txbusy), 16'd0);
    checkOutput("mrst_ovf", 16'(overflow), 16'd0);
    tick(3);
    rst = 1'b1;
    tick(1500);
    checkOutput("mrst_no_donetx", 16'(doneTxCnt - base), 16'd0);
    checkOutput("mrst_no_donerx", 16'(doneRxCnt - baseRx), 16'd0);
    dintx = 8'h69; newd = 1'b1;
    tick();
    newd = 1'b0;
    waitDoneTx("post_rst_done", 1200);
    tick(2);
    checkOutput("post_rst_valid", 16'(rx_valid), 16'd1);
    checkOutput("post_rst_data", 16'(doutrx), 16'h0069);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
